mem_port_responder: RTL and testbench

- Memory-side responder that owns the single port of a synchronous block RAM and serves two requesters: a write client (loader) and a read client (display/readback).
- Arbitrates per cycle, issues at most one RAM operation per cycle, and returns read data with a valid strobe after the fixed RAM read latency.
- Sits between the RAM IP (clka/addra/dina/douta/wea) and the logic that today drives that port directly, so loader and reader no longer mux addresses themselves.

---
 rtl/mem_port_responder.sv | 121 ++++++++++++
 tb/tb_mem_port_responder.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_port_responder                                              |
// | Purpose  : Single-port block-RAM owner arbitrating a write client and a    |
// |            pipelined read client; returns read data with a valid strobe.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mem_port_responder #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 16,
    parameter int RD_LAT     = 1,
    parameter int MAX_WR_RUN = 4
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam logic [3:0] c_MAX_RUN = 4'(MAX_WR_RUN);

    logic [3:0]        r_wr_run;
    logic              w_wr_grant;
    logic              w_rd_grant;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_din;
    logic              r_mem_we;
    logic [RD_LAT-1:0] r_rd_pipe;
    logic              w_rd_ret;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;

    // Writes win contention until they have taken MAX_WR_RUN grants in a row.
    always_comb begin
        w_wr_grant = rst & wr_req & (~rd_req | (r_wr_run != c_MAX_RUN));
        w_rd_grant = rst & rd_req & ~w_wr_grant;
    end

    assign wr_ack = w_wr_grant;
    assign rd_ack = w_rd_grant;

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_wr_run <= 4'd0;
        end else if (w_rd_grant || !rd_req) begin
            r_wr_run <= 4'd0;
        end else if (w_wr_grant && (r_wr_run != c_MAX_RUN)) begin
            r_wr_run <= r_wr_run + 4'd1;
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_mem_we   <= 1'b0;
        end else begin
            r_mem_we <= w_wr_grant;
            if (w_wr_grant) begin
                r_mem_addr <= wr_addr;
                r_mem_din  <= wr_data;
            end else if (w_rd_grant) begin
                r_mem_addr <= rd_addr;
            end
        end
    end

    // Bit k set means a read was granted k+1 edges ago.
    generate
        if (RD_LAT > 1) begin : g_pipe_multi
            always_ff @(posedge CLK or negedge rst) begin
                if (!rst) begin
                    r_rd_pipe <= '0;
                end else begin
                    r_rd_pipe <= {r_rd_pipe[RD_LAT-2:0], w_rd_grant};
                end
            end
        end else begin : g_pipe_single
            always_ff @(posedge CLK or negedge rst) begin
                if (!rst) begin
                    r_rd_pipe <= '0;
                end else begin
                    r_rd_pipe <= w_rd_grant;
                end
            end
        end
    endgenerate

    assign w_rd_ret = r_rd_pipe[RD_LAT-1];

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_rd_ret;
            if (w_rd_ret) begin
                r_rd_data <= mem_dout;
            end
        end
    end

    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;
    assign mem_we   = r_mem_we;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mem_port_responder                                           |
// | Purpose  : Bench for mem_port_responder at read latencies 1, 2 and 4.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_mem_port_responder;

    localparam int ADDR_W     = 9;
    localparam int DATA_W     = 16;
    localparam int MAX_WR_RUN = 4;
    localparam int NL         = 3;

    logic              CLK = 1'b0;
    logic              rst = 1'b1;
    logic              wr_req = 1'b0;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;

    logic              wr_ack_v   [NL];
    logic              rd_ack_v   [NL];
    logic              rd_valid_v [NL];
    logic              mem_we_v   [NL];
    logic [ADDR_W-1:0] mem_addr_v [NL];
    logic [DATA_W-1:0] mem_din_v  [NL];
    logic [DATA_W-1:0] mem_dout_v [NL];
    logic [DATA_W-1:0] rd_data_v  [NL];

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    genvar g;
    generate
        for (g = 0; g < NL; g++) begin : g_lane
            localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
            logic [DATA_W-1:0] ram  [512];
            logic [DATA_W-1:0] pipe [4];

            mem_port_responder #(
                .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(L), .MAX_WR_RUN(MAX_WR_RUN)
            ) u_dut (
                .CLK     (CLK),
                .rst     (rst),
                .wr_req  (wr_req),
                .wr_addr (wr_addr),
                .wr_data (wr_data),
                .wr_ack  (wr_ack_v[g]),
                .rd_req  (rd_req),
                .rd_addr (rd_addr),
                .rd_ack  (rd_ack_v[g]),
                .rd_valid(rd_valid_v[g]),
                .rd_data (rd_data_v[g]),
                .mem_addr(mem_addr_v[g]),
                .mem_din (mem_din_v[g]),
                .mem_we  (mem_we_v[g]),
                .mem_dout(mem_dout_v[g])
            );

            initial begin
                for (int i = 0; i < 512; i++) ram[i] = '0;
                for (int i = 0; i < 4; i++) pipe[i] = '0;
            end

            // RAM: data for the address presented in a cycle is ready L edges after it was registered.
            always @(posedge CLK) begin
                if (mem_we_v[g]) ram[mem_addr_v[g]] <= mem_din_v[g];
                pipe[0] <= ram[mem_addr_v[g]];
                for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
            end

            if (L == 1) begin : g_comb
                assign mem_dout_v[g] = ram[mem_addr_v[g]];
            end else begin : g_piped
                assign mem_dout_v[g] = pipe[L-2];
            end
        end
    endgenerate

    // Reference model state
    int                cyc = 0;
    int                m_run;
    logic [DATA_W-1:0] gold [512];
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_din;
    int                q_due [NL][$];
    logic [DATA_W-1:0] q_dat [NL][$];
    logic [DATA_W-1:0] m_last [NL];
    bit                gw, gr, ev;

    // Observation logs for scenario checks
    logic [DATA_W-1:0] cap_dat [NL][$];
    int                cap_cyc [NL][$];
    int                ack_cyc [$];
    logic [15:0]       gpat = '0;
    int                gcnt = 0;
    int                mwe_cnt = 0;

    always @(negedge CLK) begin
        cyc++;
        if (!rst) begin
            m_run  = 0;
            m_we   = 1'b0;
            m_addr = '0;
            m_din  = '0;
            for (int l = 0; l < NL; l++) begin
                q_due[l].delete();
                q_dat[l].delete();
                m_last[l] = '0;
                chk("rst_wr_ack",   32'(wr_ack_v[l]),   0);
                chk("rst_rd_ack",   32'(rd_ack_v[l]),   0);
                chk("rst_mem_we",   32'(mem_we_v[l]),   0);
                chk("rst_mem_addr", 32'(mem_addr_v[l]), 0);
                chk("rst_mem_din",  32'(mem_din_v[l]),  0);
                chk("rst_rd_valid", 32'(rd_valid_v[l]), 0);
                chk("rst_rd_data",  32'(rd_data_v[l]),  0);
            end
        end else begin
            gw = wr_req && (!rd_req || (m_run < MAX_WR_RUN));
            gr = rd_req && !gw;
            for (int l = 0; l < NL; l++) begin
                ev = (q_due[l].size() > 0) && (q_due[l][0] == cyc);
                if (ev) begin
                    void'(q_due[l].pop_front());
                    m_last[l] = q_dat[l].pop_front();
                end
                chk("wr_ack",   32'(wr_ack_v[l]),   32'(gw));
                chk("rd_ack",   32'(rd_ack_v[l]),   32'(gr));
                chk("mem_we",   32'(mem_we_v[l]),   32'(m_we));
                chk("mem_addr", 32'(mem_addr_v[l]), 32'(m_addr));
                chk("mem_din",  32'(mem_din_v[l]),  32'(m_din));
                chk("rd_valid", 32'(rd_valid_v[l]), 32'(ev));
                chk("rd_data",  32'(rd_data_v[l]),  32'(m_last[l]));
                if (rd_valid_v[l]) begin
                    cap_dat[l].push_back(rd_data_v[l]);
                    cap_cyc[l].push_back(cyc);
                end
            end
            if (rd_ack_v[0]) ack_cyc.push_back(cyc);
            if (wr_ack_v[0] || rd_ack_v[0]) begin
                gpat = {gpat[14:0], wr_ack_v[0]};
                gcnt++;
            end
            if (mem_we_v[0]) mwe_cnt++;

            if (gw) begin
                m_we   = 1'b1;
                m_addr = wr_addr;
                m_din  = wr_data;
                gold[wr_addr] = wr_data;
            end else if (gr) begin
                m_we   = 1'b0;
                m_addr = rd_addr;
                for (int l = 0; l < NL; l++) begin
                    q_due[l].push_back(cyc + lat_of(l) + 1);
                    q_dat[l].push_back(gold[rd_addr]);
                end
            end else begin
                m_we = 1'b0;
            end
            if (gr || !rd_req) m_run = 0;
            else if (gw) m_run++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_write(input int a, input int d);
        int n = 0;
        wr_req  = 1'b1;
        wr_addr = 9'(a);
        wr_data = 16'(d);
        @(negedge CLK);
        while (!wr_ack_v[0] && n < 50) begin
            n++;
            @(negedge CLK);
        end
        if (!wr_ack_v[0]) begin
            checks++;
            errors++;
            $display("FAIL wr_timeout: got no wr_ack expected wr_ack within 50 cycles");
        end
        @(posedge CLK);
        #1 wr_req = 1'b0;
    endtask

    task automatic do_read(input int a);
        int n = 0;
        rd_req  = 1'b1;
        rd_addr = 9'(a);
        @(negedge CLK);
        while (!rd_ack_v[0] && n < 50) begin
            n++;
            @(negedge CLK);
        end
        if (!rd_ack_v[0]) begin
            checks++;
            errors++;
            $display("FAIL rd_timeout: got no rd_ack expected rd_ack within 50 cycles");
        end
        @(posedge CLK);
        #1 rd_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [DATA_W-1:0] exp4 [4];
        logic [DATA_W-1:0] exp_t4 [3];
        int                exp_lat [NL];
        int                cb [NL];
        int                a0, g0, w0;
        bit                aw, ar;

        exp4    = '{16'h0001, 16'h0010, 16'h0100, 16'h1000};
        exp_t4  = '{16'hBEEF, 16'hBEEF, 16'h1234};
        exp_lat = '{2, 3, 5};
        for (int i = 0; i < 512; i++) gold[i] = '0;

        #2 rst = 1'b0;
        repeat (3) @(posedge CLK);
        #1 rst = 1'b1;
        idle(1);
        chk("reset_mem_addr", 32'(mem_addr_v[0]), 0);
        chk("reset_rd_valid", 32'(rd_valid_v[2]), 0);

        // Four back-to-back writes
        g0 = gcnt;
        w0 = mwe_cnt;
        do_write(0, 16'h0001);
        do_write(1, 16'h0010);
        do_write(2, 16'h0100);
        do_write(3, 16'h1000);
        idle(2);
        chk("t1_grants", 32'(gcnt - g0), 4);
        chk("t1_all_writes", 32'(gpat[3:0]), 32'h0000_000F);
        chk("t1_mem_we_cycles", 32'(mwe_cnt - w0), 4);

        // Back-to-back reads at every latency
        for (int l = 0; l < NL; l++) cb[l] = cap_dat[l].size();
        a0 = ack_cyc.size();
        for (int a = 0; a < 4; a++) do_read(a);
        idle(8);
        for (int l = 0; l < NL; l++) begin
            chk("t2_count", 32'(cap_dat[l].size() - cb[l]), 4);
            for (int k = 0; k < 4; k++) chk("t2_data", 32'(cap_dat[l][cb[l]+k]), 32'(exp4[k]));
            chk("t2_first_latency", 32'(cap_cyc[l][cb[l]] - ack_cyc[a0]), 32'(exp_lat[l]));
            chk("t2_back_to_back", 32'(cap_cyc[l][cb[l]+3] - cap_cyc[l][cb[l]]), 3);
        end

        // Sustained contention: writes take at most four grants in a row
        g0 = gcnt;
        wr_req  = 1'b1;
        wr_addr = 9'd8;
        wr_data = 16'hAAAA;
        rd_req  = 1'b1;
        rd_addr = 9'd0;
        repeat (12) @(posedge CLK);
        #1;
        wr_req = 1'b0;
        rd_req = 1'b0;
        idle(6);
        chk("t3_grants", 32'(gcnt - g0), 12);
        chk("t3_pattern", 32'(gpat[11:0]), 32'h0000_0F7B);

        // Read-after-write and read-before-write ordering
        for (int l = 0; l < NL; l++) cb[l] = cap_dat[l].size();
        do_write(5, 16'hBEEF);
        do_read(5);
        do_read(5);
        do_write(5, 16'h1234);
        do_read(5);
        idle(8);
        for (int l = 0; l < NL; l++) begin
            chk("t4_count", 32'(cap_dat[l].size() - cb[l]), 3);
            for (int k = 0; k < 3; k++) chk("t4_data", 32'(cap_dat[l][cb[l]+k]), 32'(exp_t4[k]));
        end

        // Reset with reads in flight
        for (int l = 0; l < NL; l++) cb[l] = cap_dat[l].size();
        do_read(2);
        do_read(3);
        rst = 1'b0;
        idle(3);
        rst = 1'b1;
        idle(6);
        for (int l = 0; l < NL; l++) chk("t5_dropped", 32'(cap_dat[l].size() - cb[l]), 0);
        do_read(1);
        idle(8);
        for (int l = 0; l < NL; l++) begin
            chk("t5_after_count", 32'(cap_dat[l].size() - cb[l]), 1);
            chk("t5_after_data", 32'(cap_dat[l][cb[l]]), 32'h0000_0010);
        end

        // Random traffic; requests held until accepted
        for (int n = 0; n < 500; n++) begin
            @(negedge CLK);
            aw = wr_req && wr_ack_v[0];
            ar = rd_req && rd_ack_v[0];
            @(posedge CLK);
            #1;
            if (!wr_req || aw) begin
                wr_req  = ($urandom % 4) != 0;
                wr_addr = 9'($urandom_range(0, 15));
                wr_data = 16'($urandom);
            end
            if (!rd_req || ar) begin
                rd_req  = ($urandom % 3) != 0;
                rd_addr = 9'($urandom_range(0, 15));
            end
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        idle(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
